pc_sequencer: RTL and testbench

Instruction-fetch sequencer for the 8-bit accumulator-style core. Owns the program counter that addresses the instruction ROM, starts a selected program from a fixed base address, and resolves halt, conditional forward and conditional backward branches. Sits between the top-level start/done handshake and the ROM/datapath pair. Datapath instructions execute in the same cycle they are presented.

---
 rtl/pc_seq_pkg.sv | 32 +++
 rtl/pc_next_calc.sv | 30 +++
 rtl/pc_sequencer.sv | 100 ++++++++++
 tb/tb_pc_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package pc_seq_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 8;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned PFX_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [INSTR_W-1:0] HALT_INSTR = 8'h88;
    localparam logic [PFX_W-1:0]   BR_FWD_PFX = 5'b11110;
    localparam logic [PFX_W-1:0]   BR_BWD_PFX = 5'b10110;

    localparam logic [PC_W-1:0] PROG0_BASE = 8'd0;
    localparam logic [PC_W-1:0] PROG1_BASE = 8'd98;
    localparam logic [PC_W-1:0] PROG2_BASE = 8'd145;

    // Unused select value 3 falls back to the multiplication program.
    function automatic logic [PC_W-1:0] prog_base(input logic [1:0] sel);
        case (sel)
            2'd1:    prog_base = PROG1_BASE;
            2'd2:    prog_base = PROG2_BASE;
            default: prog_base = PROG0_BASE;
        endcase
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC and halt decode for one presented instruction (pure combinational).
module pc_next_calc
    import pc_seq_pkg::*;
(
    input  logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               flag,
    input  logic [PC_W-1:0]    offset,
    output logic [PC_W-1:0]    next_pc,
    output logic               is_halt
);

    logic is_fwd;
    logic is_bwd;

    assign is_fwd  = (instr[INSTR_W-1:INSTR_W-PFX_W] == BR_FWD_PFX);
    assign is_bwd  = (instr[INSTR_W-1:INSTR_W-PFX_W] == BR_BWD_PFX);
    assign is_halt = (instr == HALT_INSTR);

    // Branch arithmetic wraps modulo 256 by construction of the 8-bit sum.
    always_comb begin
        next_pc = pc + PC_W'(1);
        if (is_fwd && flag) begin
            next_pc = pc + offset;
        end else if (is_bwd && flag) begin
            next_pc = pc - offset;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: start/halt FSM, branch resolution, optional
// executed-instruction counter enabled by PC_SEQ_CYCLE_CNT_EN.
module pc_sequencer
    import pc_seq_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [1:0]         prog_sel_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               flag_i,
    input  logic [PC_W-1:0]    offset_i,
    input  logic               stall_i,
    output logic [PC_W-1:0]    pc_o,
    output logic               instr_valid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   cycle_cnt_o
);

    state_t          state;
    state_t          state_next;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] calc_pc;
    logic            calc_halt;

    pc_next_calc u_next (
        .pc      (pc_o),
        .instr   (instr_i),
        .flag    (flag_i),
        .offset  (offset_i),
        .next_pc (calc_pc),
        .is_halt (calc_halt)
    );

    assign instr_valid_o = (state == ST_RUN) && !stall_i;

    // State and registered status outputs; busy/done track the next state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state  <= ST_IDLE;
            pc_o   <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state  <= state_next;
            pc_o   <= pc_next;
            busy_o <= (state_next == ST_RUN);
            done_o <= (state_next == ST_DONE);
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc_o;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    pc_next    = prog_base(prog_sel_i);
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall_i) begin
                    if (calc_halt) begin
                        state_next = ST_DONE;
                    end else begin
                        pc_next = calc_pc;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

`ifdef PC_SEQ_CYCLE_CNT_EN
    logic             start_acc;
    logic [CNT_W-1:0] cnt;

    assign start_acc = (state != ST_RUN) && start_i;

    // Saturating count of executed instructions, restarted per program run.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt <= '0;
        end else if (start_acc) begin
            cnt <= '0;
        end else if (instr_valid_o && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign cycle_cnt_o = cnt;
`else
    assign cycle_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed literal scenarios plus a
// randomized run against a behavioural reference model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  prog_sel_i = 2'd0;
    logic [7:0]  instr_i;
    logic        flag_i = 1'b0;
    logic [7:0]  offset_i = 8'd0;
    logic        stall_i = 1'b0;
    logic [7:0]  pc_o;
    logic        instr_valid_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] cycle_cnt_o;

    logic [7:0]  rom [256];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign instr_i = rom[pc_o];

    pc_sequencer dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .prog_sel_i    (prog_sel_i),
        .instr_i       (instr_i),
        .flag_i        (flag_i),
        .offset_i      (offset_i),
        .stall_i       (stall_i),
        .pc_o          (pc_o),
        .instr_valid_o (instr_valid_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .cycle_cnt_o   (cycle_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_cnt(input int n);
`ifdef PC_SEQ_CYCLE_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    function automatic int base_of(input int sel);
        if (sel == 1) return 98;
        if (sel == 2) return 145;
        return 0;
    endfunction

    // Reference model: running/done flags, PC as an integer mod 256, plain count.
    bit m_run  = 1'b0;
    bit m_done = 1'b0;
    int m_pc   = 0;
    int m_cnt  = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        int ins;
        int pfx;
        ins = int'(rom[m_pc[7:0]]);
        pfx = ins / 8;
        if (reset_i) begin
            m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
        end else if (!m_run) begin
            if (start_i) begin
                m_pc = base_of(int'(prog_sel_i));
                m_run = 1; m_done = 0; m_cnt = 0;
            end
        end else if (!stall_i) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (ins == 136) begin
                m_run = 0; m_done = 1;
            end else if (pfx == 30 && flag_i) begin
                m_pc = (m_pc + int'(offset_i)) % 256;
            end else if (pfx == 22 && flag_i) begin
                m_pc = (m_pc - int'(offset_i) + 256) % 256;
            end else begin
                m_pc = (m_pc + 1) % 256;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_pc",    32'(pc_o),          32'(m_pc));
            chk("model_busy",  32'(busy_o),        32'(m_run));
            chk("model_done",  32'(done_o),        32'(m_done));
            chk("model_valid", 32'(instr_valid_o), 32'(m_run && !stall_i));
            chk("model_cnt",   32'(cycle_cnt_o),   32'(exp_cnt(m_cnt)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic advance_to(input int target);
        int k;
        k = 0;
        while (pc_o !== 8'(target) && k < 400) begin
            tick();
            k++;
        end
        chk("reach_pc", 32'(pc_o), 32'(target));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;

        // Reset state
        reset_i = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("rst_pc",    32'(pc_o),          32'd0);
        chk("rst_busy",  32'(busy_o),        32'd0);
        chk("rst_done",  32'(done_o),        32'd0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_cnt",   32'(cycle_cnt_o),   32'd0);

        // Program 1 over NOPs
        prog_sel_i = 2'd1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("p1_pc0",   32'(pc_o),   32'd98);
        chk("p1_busy",  32'(busy_o), 32'd1);
        chk("p1_cnt0",  32'(cycle_cnt_o), 32'(exp_cnt(0)));
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("p1_pc",  32'(pc_o),        32'(98 + i));
            chk("p1_cnt", 32'(cycle_cnt_o), 32'(exp_cnt(i)));
        end

        // Branch scenarios from program 0
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        rom[5]  = 8'hB6;
        rom[17] = 8'hF7;
        rom[49] = 8'hB6;
        rom[97] = 8'h88;
        prog_sel_i = 2'd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        advance_to(5);
        flag_i = 1'b1; offset_i = 8'd10;
        tick();
        flag_i = 1'b0;
        chk("bwd_wrap", 32'(pc_o), 32'd251);
        advance_to(17);
        tick();
        chk("fwd_not_taken", 32'(pc_o), 32'd18);
        advance_to(49);
        flag_i = 1'b1; offset_i = 8'd37;
        tick();
        flag_i = 1'b0;
        chk("bwd_taken", 32'(pc_o), 32'd12);
        advance_to(17);
        flag_i = 1'b1; offset_i = 8'd8;
        tick();
        flag_i = 1'b0;
        chk("fwd_taken", 32'(pc_o), 32'd25);

        // Stall for 3 cycles with a start pulse in the middle
        tick();
        tick();
        stall_i = 1'b1;
        #1;
        chk("stall_valid", 32'(instr_valid_o), 32'd0);
        tick();
        start_i = 1'b1; prog_sel_i = 2'd2;
        tick();
        start_i = 1'b0;
        tick();
        chk("stall_pc",   32'(pc_o),   32'd27);
        chk("stall_busy", 32'(busy_o), 32'd1);
        stall_i = 1'b0;
        tick();
        chk("post_stall_pc", 32'(pc_o), 32'd28);

        // Reset mid-run
        advance_to(60);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("mid_rst_pc",    32'(pc_o),          32'd0);
        chk("mid_rst_busy",  32'(busy_o),        32'd0);
        chk("mid_rst_done",  32'(done_o),        32'd0);
        chk("mid_rst_valid", 32'(instr_valid_o), 32'd0);
        chk("mid_rst_cnt",   32'(cycle_cnt_o),   32'd0);

        // Halt at 97 (select 3 maps to base 0), then restart program 2
        prog_sel_i = 2'd3;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("sel3_pc", 32'(pc_o), 32'd0);
        advance_to(97);
        tick();
        chk("halt_done", 32'(done_o), 32'd1);
        chk("halt_busy", 32'(busy_o), 32'd0);
        chk("halt_pc",   32'(pc_o),   32'd97);
        tick();
        chk("halt_hold_pc",   32'(pc_o),   32'd97);
        chk("halt_hold_done", 32'(done_o), 32'd1);
        prog_sel_i = 2'd2;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("restart_pc",   32'(pc_o),   32'd145);
        chk("restart_done", 32'(done_o), 32'd0);
        chk("restart_busy", 32'(busy_o), 32'd1);

        // Randomized run with a branch/halt-rich ROM
        reset_i = 1'b1;
        for (int i = 0; i < 256; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 12)      rom[i] = {5'b11110, 3'($urandom)};
            else if (r < 24) rom[i] = {5'b10110, 3'($urandom)};
            else if (r < 28) rom[i] = 8'h88;
            else             rom[i] = 8'($urandom);
        end
        tick();
        reset_i = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            start_i    = ($urandom % 6) == 0;
            prog_sel_i = 2'($urandom);
            stall_i    = ($urandom % 4) == 0;
            flag_i     = 1'($urandom);
            offset_i   = 8'($urandom);
            reset_i    = ($urandom % 250) == 0;
            tick();
        end
        start_i = 1'b0; stall_i = 1'b0; reset_i = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
